fetch_warp_sched: RTL and testbench

- Per-core warp scheduler that sequences the instruction-fetch stage.
- Tracks state, PC and thread mask for every warp.
- Round-robin selects one fetch-eligible warp per cycle and presents it on a registered valid/ready schedule port feeding the fetch unit.
- Holds each issued warp stalled until decode/execute returns an unlock carrying the next PC and mask. This enforces at most one outstanding fetch per warp.

---
 rtl/fetch_warp_sched.sv | 178 +++++++++++++++++
 tb/tb_fetch_warp_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_warp_sched.sv
// ============================================================================
// fetch_warp_sched : round-robin warp scheduler feeding the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_warp_sched #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int PC_BITS     = 30,
   parameter int UUID_WIDTH  = 16,
   localparam int WID_W      = $clog2(NUM_WARPS)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_valid_i,
   input  logic [WID_W-1:0]       start_wid_i,
   input  logic [PC_BITS-1:0]     start_pc_i,
   input  logic [NUM_THREADS-1:0] start_tmask_i,
   input  logic                   unlock_valid_i,
   input  logic [WID_W-1:0]       unlock_wid_i,
   input  logic                   unlock_branch_i,
   input  logic [PC_BITS-1:0]     unlock_pc_i,
   input  logic [NUM_THREADS-1:0] unlock_tmask_i,
   output logic                   sched_valid_o,
   input  logic                   sched_ready_i,
   output logic [WID_W-1:0]       sched_wid_o,
   output logic [PC_BITS-1:0]     sched_pc_o,
   output logic [NUM_THREADS-1:0] sched_tmask_o,
   output logic [UUID_WIDTH-1:0]  sched_uuid_o,
   output logic [NUM_WARPS-1:0]   active_warps_o,
   output logic                   busy_o
);

   typedef enum logic [1:0] {
      WS_INACTIVE = 2'd0,
      WS_READY    = 2'd1,
      WS_STALLED  = 2'd2
   } warp_state_e;

   warp_state_e            state_q [NUM_WARPS];
   warp_state_e            state_d [NUM_WARPS];
   logic [PC_BITS-1:0]     pc_q    [NUM_WARPS];
   logic [PC_BITS-1:0]     pc_d    [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];

   logic [WID_W-1:0]       rr_q, rr_d;
   logic [UUID_WIDTH-1:0]  uuid_q, uuid_d;
   logic                   sched_valid_q, sched_valid_d;
   logic [WID_W-1:0]       sched_wid_q, sched_wid_d;
   logic [PC_BITS-1:0]     sched_pc_q, sched_pc_d;
   logic [NUM_THREADS-1:0] sched_tmask_q, sched_tmask_d;
   logic [UUID_WIDTH-1:0]  sched_uuid_q, sched_uuid_d;

   logic                   load;
   logic                   sel_found;
   logic [WID_W-1:0]       sel_wid;
   logic [WID_W-1:0]       cand;

   assign load = !sched_valid_q || sched_ready_i;

   // First READY warp scanning upward from the round-robin pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_wid   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         cand = rr_q + WID_W'(i);
         if (!sel_found && state_q[cand] == WS_READY) begin
            sel_found = 1'b1;
            sel_wid   = cand;
         end
      end
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         state_d[w] = state_q[w];
         pc_d[w]    = pc_q[w];
         tmask_d[w] = tmask_q[w];
         case (state_q[w])
            WS_INACTIVE: begin
               if (start_valid_i && start_wid_i == WID_W'(w) &&
                   start_pc_i != '0 && start_tmask_i != '0) begin
                  state_d[w] = WS_READY;
                  pc_d[w]    = start_pc_i;
                  tmask_d[w] = start_tmask_i;
               end
            end
            WS_READY: begin
               if (load && sel_found && sel_wid == WID_W'(w))
                  state_d[w] = WS_STALLED;
            end
            WS_STALLED: begin
               if (unlock_valid_i && unlock_wid_i == WID_W'(w)) begin
                  if (unlock_tmask_i != '0) begin
                     state_d[w] = WS_READY;
                     pc_d[w]    = unlock_branch_i ? unlock_pc_i : pc_q[w] + PC_BITS'(1);
                     tmask_d[w] = unlock_tmask_i;
                  end else begin
                     state_d[w] = WS_INACTIVE;
                  end
               end
            end
            default: state_d[w] = WS_INACTIVE;
         endcase
      end
   end

   // Output register holds while the fetch unit back-pressures.
   always_comb begin
      sched_valid_d = sched_valid_q;
      sched_wid_d   = sched_wid_q;
      sched_pc_d    = sched_pc_q;
      sched_tmask_d = sched_tmask_q;
      sched_uuid_d  = sched_uuid_q;
      uuid_d        = uuid_q;
      rr_d          = rr_q;
      if (load) begin
         sched_valid_d = sel_found;
         if (sel_found) begin
            sched_wid_d   = sel_wid;
            sched_pc_d    = pc_q[sel_wid];
            sched_tmask_d = tmask_q[sel_wid];
            sched_uuid_d  = uuid_q;
            uuid_d        = uuid_q + UUID_WIDTH'(1);
            rr_d          = sel_wid + WID_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= WS_INACTIVE;
            pc_q[w]    <= '0;
            tmask_q[w] <= '0;
         end
         rr_q          <= '0;
         uuid_q        <= '0;
         sched_valid_q <= 1'b0;
         sched_wid_q   <= '0;
         sched_pc_q    <= '0;
         sched_tmask_q <= '0;
         sched_uuid_q  <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= state_d[w];
            pc_q[w]    <= pc_d[w];
            tmask_q[w] <= tmask_d[w];
         end
         rr_q          <= rr_d;
         uuid_q        <= uuid_d;
         sched_valid_q <= sched_valid_d;
         sched_wid_q   <= sched_wid_d;
         sched_pc_q    <= sched_pc_d;
         sched_tmask_q <= sched_tmask_d;
         sched_uuid_q  <= sched_uuid_d;
      end
   end

   always_comb begin
      active_warps_o = '0;
      for (int w = 0; w < NUM_WARPS; w++)
         active_warps_o[w] = (state_q[w] != WS_INACTIVE);
   end

   assign busy_o        = |active_warps_o;
   assign sched_valid_o = sched_valid_q;
   assign sched_wid_o   = sched_wid_q;
   assign sched_pc_o    = sched_pc_q;
   assign sched_tmask_o = sched_tmask_q;
   assign sched_uuid_o  = sched_uuid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_warp_sched.sv
// ============================================================================
// tb_fetch_warp_sched : directed self-checking bench for fetch_warp_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_warp_sched;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_valid_i;
   logic [1:0]  start_wid_i;
   logic [29:0] start_pc_i;
   logic [3:0]  start_tmask_i;
   logic        unlock_valid_i;
   logic [1:0]  unlock_wid_i;
   logic        unlock_branch_i;
   logic [29:0] unlock_pc_i;
   logic [3:0]  unlock_tmask_i;
   logic        sched_valid_o;
   logic        sched_ready_i;
   logic [1:0]  sched_wid_o;
   logic [29:0] sched_pc_o;
   logic [3:0]  sched_tmask_o;
   logic [15:0] sched_uuid_o;
   logic [3:0]  active_warps_o;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   fetch_warp_sched dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .start_valid_i  (start_valid_i),
      .start_wid_i    (start_wid_i),
      .start_pc_i     (start_pc_i),
      .start_tmask_i  (start_tmask_i),
      .unlock_valid_i (unlock_valid_i),
      .unlock_wid_i   (unlock_wid_i),
      .unlock_branch_i(unlock_branch_i),
      .unlock_pc_i    (unlock_pc_i),
      .unlock_tmask_i (unlock_tmask_i),
      .sched_valid_o  (sched_valid_o),
      .sched_ready_i  (sched_ready_i),
      .sched_wid_o    (sched_wid_o),
      .sched_pc_o     (sched_pc_o),
      .sched_tmask_o  (sched_tmask_o),
      .sched_uuid_o   (sched_uuid_o),
      .active_warps_o (active_warps_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [1:0] wid, input logic [29:0] pc, input logic [3:0] tm);
      start_valid_i = 1'b1;
      start_wid_i   = wid;
      start_pc_i    = pc;
      start_tmask_i = tm;
   endtask

   task automatic unlock(input logic [1:0] wid, input logic br, input logic [29:0] pc,
                         input logic [3:0] tm);
      unlock_valid_i  = 1'b1;
      unlock_wid_i    = wid;
      unlock_branch_i = br;
      unlock_pc_i     = pc;
      unlock_tmask_i  = tm;
   endtask

   task automatic chk_req(input string tag, input logic [1:0] wid, input logic [29:0] pc,
                          input logic [3:0] tm, input logic [15:0] uuid);
      chk({tag, "_valid"}, sched_valid_o, 1'b1);
      chk({tag, "_wid"},   sched_wid_o,   wid);
      chk({tag, "_pc"},    sched_pc_o,    pc);
      chk({tag, "_tmask"}, sched_tmask_o, tm);
      chk({tag, "_uuid"},  sched_uuid_o,  uuid);
   endtask

   initial begin
      logic [15:0] exp_uuid;
      int          n_obs;

      reset_i = 1'b1;
      start_valid_i = 1'b0; start_wid_i = '0; start_pc_i = '0; start_tmask_i = '0;
      unlock_valid_i = 1'b0; unlock_wid_i = '0; unlock_branch_i = 1'b0;
      unlock_pc_i = '0; unlock_tmask_i = '0;
      sched_ready_i = 1'b0;
      tick(); tick();
      chk("rst_valid", sched_valid_o, 1'b0);
      chk("rst_active", active_warps_o, 4'b0000);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_pc", sched_pc_o, 30'h0);
      chk("rst_uuid", sched_uuid_o, 16'h0);
      reset_i = 1'b0;

      // Single warp: start, issue two cycles later, sequential unlock.
      sched_ready_i = 1'b1;
      start(2'd0, 30'h100, 4'hF);
      tick(); start_valid_i = 1'b0;
      chk("s1_valid_early", sched_valid_o, 1'b0);
      chk("s1_active", active_warps_o, 4'b0001);
      tick(); chk_req("s1_issue", 2'd0, 30'h100, 4'hF, 16'd0);
      tick(); chk("s1_drain", sched_valid_o, 1'b0);
      unlock(2'd0, 1'b0, 30'h0, 4'b0011);
      tick(); unlock_valid_i = 1'b0;
      chk("s1_unlock_lat", sched_valid_o, 1'b0);
      tick(); chk_req("s1_seq", 2'd0, 30'h101, 4'b0011, 16'd1);
      tick(); chk("s1_drain2", sched_valid_o, 1'b0);

      // Back-pressure with wid1 pending while other warps become READY.
      sched_ready_i = 1'b0;
      start(2'd1, 30'h200, 4'hF);
      tick(); chk("s2_valid0", sched_valid_o, 1'b0);
      start(2'd2, 30'h300, 4'hF);
      tick(); chk_req("s2_w1", 2'd1, 30'h200, 4'hF, 16'd2);
      start(2'd3, 30'h400, 4'hF);
      tick(); start_valid_i = 1'b0;
      unlock(2'd0, 1'b1, 30'h500, 4'hF);
      tick(); unlock_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_req("s2_hold", 2'd1, 30'h200, 4'hF, 16'd2);
      end
      chk("s2_active", active_warps_o, 4'b1111);
      sched_ready_i = 1'b1;
      tick(); chk_req("s2_rr2", 2'd2, 30'h300, 4'hF, 16'd3);
      tick(); chk_req("s2_rr3", 2'd3, 30'h400, 4'hF, 16'd4);
      tick(); chk_req("s2_rr0", 2'd0, 30'h500, 4'hF, 16'd5);
      tick(); chk("s2_drain", sched_valid_o, 1'b0);

      // Earlier unlock of wid2 wins over later unlock of wid0.
      unlock(2'd2, 1'b0, 30'h0, 4'hF);
      tick();
      unlock(2'd0, 1'b0, 30'h0, 4'hF);
      tick(); unlock_valid_i = 1'b0;
      chk_req("s3_w2", 2'd2, 30'h301, 4'hF, 16'd6);
      tick(); chk_req("s3_w0", 2'd0, 30'h501, 4'hF, 16'd7);
      tick(); chk("s3_drain", sched_valid_o, 1'b0);

      // Ignored operations, termination and same-cycle start/unlock.
      start(2'd1, 30'h999, 4'hF);
      tick(); start_valid_i = 1'b0;
      tick(); chk("s4_start_active_ign", sched_valid_o, 1'b0);
      chk("s4_active_all", active_warps_o, 4'b1111);
      unlock(2'd1, 1'b0, 30'h0, 4'h0);
      tick(); unlock_valid_i = 1'b0;
      chk("s4_term1", active_warps_o, 4'b1101);
      chk("s4_busy", busy_o, 1'b1);
      unlock(2'd1, 1'b0, 30'h0, 4'hF);
      tick(); unlock_valid_i = 1'b0;
      tick(); chk("s4_unl_inact_act", active_warps_o, 4'b1101);
      chk("s4_unl_inact_valid", sched_valid_o, 1'b0);
      start(2'd1, 30'h0, 4'hF);
      tick();
      start(2'd1, 30'h10, 4'h0);
      tick(); start_valid_i = 1'b0;
      tick(); chk("s4_bad_start_act", active_warps_o, 4'b1101);
      chk("s4_bad_start_valid", sched_valid_o, 1'b0);
      start(2'd1, 30'h600, 4'b0001);
      unlock(2'd3, 1'b0, 30'h0, 4'h0);
      tick(); start_valid_i = 1'b0; unlock_valid_i = 1'b0;
      chk("s4_both_diff", active_warps_o, 4'b0111);
      tick(); chk_req("s4_w1", 2'd1, 30'h600, 4'b0001, 16'd8);
      tick(); chk("s4_drain", sched_valid_o, 1'b0);
      unlock(2'd1, 1'b0, 30'h0, 4'b0010);
      start(2'd1, 30'h700, 4'hF);
      tick(); start_valid_i = 1'b0; unlock_valid_i = 1'b0;
      tick(); chk_req("s4_same_wid", 2'd1, 30'h601, 4'b0010, 16'd9);
      tick(); chk("s4_drain2", sched_valid_o, 1'b0);
      unlock(2'd0, 1'b0, 30'h0, 4'h0); tick();
      unlock(2'd1, 1'b0, 30'h0, 4'h0); tick();
      chk("s4_busy_mid", busy_o, 1'b1);
      unlock(2'd2, 1'b0, 30'h0, 4'h0); tick(); unlock_valid_i = 1'b0;
      chk("s4_all_done", active_warps_o, 4'b0000);
      chk("s4_busy_low", busy_o, 1'b0);

      // PC wrap on sequential unlock.
      start(2'd0, 30'h3FFF_FFFF, 4'hF);
      tick(); start_valid_i = 1'b0;
      tick(); chk_req("s5_max", 2'd0, 30'h3FFF_FFFF, 4'hF, 16'd10);
      tick();
      unlock(2'd0, 1'b0, 30'h0, 4'hF);
      tick(); unlock_valid_i = 1'b0;
      tick(); chk_req("s5_wrap", 2'd0, 30'h0, 4'hF, 16'd11);
      tick(); chk("s5_drain", sched_valid_o, 1'b0);

      // Full-throughput stream across the uuid wrap; each issued warp is
      // unlocked as it is accepted so the pipe never runs dry.
      exp_uuid = 16'd12;
      n_obs = 0;
      unlock(2'd0, 1'b0, 30'h0, 4'hF);
      start(2'd1, 30'h10, 4'hF);
      for (int cyc = 0; cyc < 70000 && n_obs < 65530; cyc++) begin
         tick();
         if (cyc < 2) start(2'(cyc + 2), 30'h10, 4'hF);
         else start_valid_i = 1'b0;
         if (sched_valid_o) begin
            if (exp_uuid >= 16'hFFFE || exp_uuid <= 16'd1)
               chk("s6_uuid", sched_uuid_o, exp_uuid);
            exp_uuid = exp_uuid + 16'd1;
            n_obs++;
            unlock(sched_wid_o, 1'b0, 30'h0, 4'hF);
         end else begin
            unlock_valid_i = 1'b0;
         end
      end
      chk("s6_stream_count", n_obs, 65530);
      unlock_valid_i = 1'b0;
      start_valid_i  = 1'b0;
      sched_ready_i  = 1'b0;
      tick(); chk("s6_pending", sched_valid_o, 1'b1);

      // Asynchronous reset mid-operation.
      #3 reset_i = 1'b1;
      #1;
      chk("s7_async_valid", sched_valid_o, 1'b0);
      chk("s7_async_active", active_warps_o, 4'b0000);
      chk("s7_async_busy", busy_o, 1'b0);
      chk("s7_async_uuid", sched_uuid_o, 16'h0);
      tick(); reset_i = 1'b0;
      sched_ready_i = 1'b1;
      start(2'd2, 30'h40, 4'hF);
      tick(); start_valid_i = 1'b0;
      tick(); chk_req("s7_restart", 2'd2, 30'h40, 4'hF, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
